// File: rtl/sra_pkg.sv
// Shared definitions for the sra_accumulator block: FSM state encoding,
// default parameter values and the counter-width helper.
package sra_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 10;
    localparam int DEF_BEATS     = 8;
    localparam int DEF_ACC_WIDTH = 16;

    // Number of bits needed to encode values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sra_acc_addsat.sv
// Combinational accumulator adder. With SRA_ACC_SATURATE_EN defined the sum
// clamps to all-ones on carry-out and the overflow is reported; otherwise
// the sum wraps modulo 2^ACC_WIDTH and no overflow port exists.
module sra_acc_addsat #(
    parameter int ACC_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0] i_a,
    input  logic [ACC_WIDTH-1:0] i_b,
`ifdef SRA_ACC_SATURATE_EN
    output logic                 o_ovf,
`endif
    output logic [ACC_WIDTH-1:0] o_sum
);

`ifdef SRA_ACC_SATURATE_EN
    logic [ACC_WIDTH:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b};
    assign o_ovf  = w_full[ACC_WIDTH];
    assign o_sum  = w_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];
`else
    assign o_sum  = i_a + i_b;
`endif

endmodule

// File: rtl/sra_accumulator.sv
// Block accumulator for carry-select adder results. Sums {c_out, s} beats
// until BEATS are taken or in_last closes the block, then holds the total on
// a valid/ready port. Optional macro SRA_ACC_SATURATE_EN enables saturation
// with a sticky out_sat flag; without it the sum wraps and out_sat is 0.
module sra_accumulator
    import sra_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int BEATS     = DEF_BEATS,
    parameter  int ACC_WIDTH = DEF_ACC_WIDTH,
    localparam int CNT_WIDTH = clog2(BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_s,
    input  logic                 in_c_out,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_sat
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_beat;
    logic [ACC_WIDTH-1:0] w_sum;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 w_accept;
    logic                 w_close;
    logic                 w_consume;

    // Handshakes are decoded from registered state only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;
    assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
    assign w_close   = (w_cnt_inc == CNT_WIDTH'(BEATS)) || in_last;

    // Zero-extend the adder result (carry-out is the top bit of the beat).
    always_comb begin
        w_beat            = '0;
        w_beat[WIDTH:0]   = {in_c_out, in_s};
    end

`ifdef SRA_ACC_SATURATE_EN
    logic w_ovf;
    logic r_sat;
`endif

    sra_acc_addsat #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_addsat (
        .i_a   (r_acc),
        .i_b   (w_beat),
`ifdef SRA_ACC_SATURATE_EN
        .o_ovf (w_ovf),
`endif
        .o_sum (w_sum)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: clear wins, otherwise close a block or release a result.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ACCUM;
        end else if (w_accept && w_close) begin
            w_state_nxt = HOLD;
        end else if (w_consume) begin
            w_state_nxt = ACCUM;
        end
    end

    // Accumulator and beat counter; both hold their final values in HOLD
    // and are reused directly as the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clear || w_consume) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
        end
    end

`ifdef SRA_ACC_SATURATE_EN
    // Sticky saturation flag for the current block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat <= 1'b0;
        end else if (clear || w_consume) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= r_sat | w_ovf;
        end
    end

    assign out_sat = r_sat;
`else
    assign out_sat = 1'b0;
`endif

    assign out_sum   = r_acc;
    assign out_count = r_cnt;

endmodule

// File: tb/tb_sra_accumulator.sv
// Scoreboard bench for sra_accumulator (WIDTH=10, BEATS=4, ACC_WIDTH=12).
// Expected block results are modelled when beats are driven and compared
// when the DUT completes an output handshake.
module tb_sra_accumulator;

    localparam int W  = 10;
    localparam int B  = 4;
    localparam int AW = 12;
    localparam int CW = 3;

    typedef struct packed {
        logic [AW-1:0] sum;
        logic [CW-1:0] cnt;
        logic          sat;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_s;
    logic          in_c_out;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_sat;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [AW-1:0] m_acc;
    int            m_cnt;
    logic          m_sat;
    int            n_checks;
    int            n_fail;

    sra_accumulator #(
        .WIDTH     (W),
        .BEATS     (B),
        .ACC_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_c_out  (in_c_out),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_cnt = 0;
        m_sat = 1'b0;
    endtask

    // Reference behaviour of one accepted beat.
    task automatic model_accept(input logic [W-1:0] s, input logic c, input logic last);
        logic [AW:0] t;
        exp_t        e;
        t = {1'b0, m_acc} + (AW+1)'({c, s});
`ifdef SRA_ACC_SATURATE_EN
        if (t[AW]) begin
            m_acc = {AW{1'b1}};
            m_sat = 1'b1;
        end else begin
            m_acc = t[AW-1:0];
        end
`else
        m_acc = t[AW-1:0];
`endif
        m_cnt++;
        if (m_cnt == B || last) begin
            e.sum = m_acc;
            e.cnt = CW'(m_cnt);
            e.sat = m_sat;
            sb.push_back(e);
            model_reset();
        end
    endtask

    task automatic drive_beat(input logic [W-1:0] s, input logic c, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_s     = s;
        in_c_out = c;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("beat_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (guard < 50) model_accept(s, c, last);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_after_consume", 32'(out_valid), 32'd0);
        chk("ready_after_consume", 32'(in_ready), 32'd1);
    endtask

    // Output monitor: every completed handshake pops one expected block.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clear) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_sum", 32'(out_sum), 32'(mon_e.sum));
                chk("out_count", 32'(out_count), 32'(mon_e.cnt));
                chk("out_sat", 32'(out_sat), 32'(mon_e.sat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_s      = '0;
        in_c_out  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full block, back-to-back beats 1..4.
        drive_beat(10'd1, 1'b0, 1'b0);
        drive_beat(10'd2, 1'b0, 1'b0);
        drive_beat(10'd3, 1'b0, 1'b0);
        chk("early_valid", 32'(out_valid), 32'd0);
        drive_beat(10'd4, 1'b0, 1'b0);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        consume();

        // Early close via in_last with carry-out set.
        drive_beat(10'd100, 1'b0, 1'b0);
        drive_beat(10'd5, 1'b1, 1'b1);
        chk("last_valid", 32'(out_valid), 32'd1);
        consume();

        // Output stall for five cycles.
        for (int i = 0; i < B; i++) drive_beat(10'd7, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_sum", 32'(out_sum), 32'(sb[0].sum));
            chk("stall_count", 32'(out_count), 32'(sb[0].cnt));
        end
        @(posedge clk);
        #1;
        consume();

        // Maximum beats: saturate or wrap depending on build.
        for (int i = 0; i < B; i++) drive_beat(10'h3FF, 1'b1, 1'b0);
        consume();

        // in_last without in_valid is ignored; clear discards a partial block.
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_last = 1'b0;
        drive_beat(10'd50, 1'b0, 1'b0);
        drive_beat(10'd50, 1'b0, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_s     = 10'd7;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        chk("clear_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < B; i++) drive_beat(10'd1, 1'b0, 1'b0);
        consume();

        // Single-beat block.
        drive_beat(10'd9, 1'b0, 1'b1);
        consume();

        // Asynchronous reset in the middle of a cycle while holding a result.
        for (int i = 0; i < B; i++) drive_beat(10'd2, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_sum", 32'(out_sum), 32'd0);
        chk("arst_out_count", 32'(out_count), 32'd0);
        sb.delete();
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < B; i++) drive_beat(10'd1, 1'b0, 1'b0);
        consume();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sra_accumulator.md
# sra_accumulator

Downstream consumer of the square-root carry-select adder. Accepts a stream of adder results and accumulates them into a wider register. Each result is the sum bits `s` plus carry-out `c_out`. After a fixed number of beats, or an early `in_last`, it presents the block total on a valid/ready output port. It turns per-cycle adder output into block sums for the next datapath stage.

## Interface
Parameters:
- `WIDTH`, 10, adder sum width (matches adder `s`)
- `BEATS`, 8, beats per full block (≥2)
- `ACC_WIDTH`, 16, accumulator and output width (≥ WIDTH+1)
- Derived: `CNT_WIDTH` = clog2(BEATS+1)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous abort, discards current block
- `in_valid`  in  1  adder result valid
- `in_ready`  out  1  accumulator can accept a beat
- `in_s`  in  WIDTH  adder sum `s`
- `in_c_out`  in  1  adder carry-out
- `in_last`  in  1  this beat closes the block early
- `out_valid`  out  1  block result available
- `out_ready`  in  1  consumer accepts result
- `out_sum`  out  ACC_WIDTH  block total
- `out_count`  out  CNT_WIDTH  beats in the block (1..BEATS)
- `out_sat`  out  1  total saturated (see Configuration)

## Operation
- Beat value = {in_c_out, in_s}, zero-extended to ACC_WIDTH (range 0..2^(WIDTH+1)-1).
- A beat is accepted when in_valid && in_ready.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM, on accepted beat:
  - acc ← acc + beat, cnt ← cnt+1.
  - If cnt+1 == BEATS or in_last=1: → HOLD. out_sum/out_count/out_sat latch the final values.
- HOLD:
  - out_sum/out_count/out_sat stay stable while out_valid && !out_ready.
  - On out_ready: → ACCUM, acc ← 0, cnt ← 0, sat flag ← 0.
- No beat is accepted in the cycle the result is consumed (in_ready=0 throughout HOLD).
- `clear` has priority over all other events in every state:
  - → ACCUM, acc ← 0, cnt ← 0, sat ← 0, out_valid ← 0 next cycle.
  - A concurrent in beat is discarded; a concurrent output handshake is treated as completed.
- in_last with in_valid=0 is ignored.
- Wrap arithmetic without SATURATE: modulo 2^ACC_WIDTH.

## Timing
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_sat=0, acc=0, cnt=0.
- Reset assertion mid-block or during HOLD drops out_valid and clears all state asynchronously.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- Output throughput: one result per (beats + 1 + output-stall) cycles; minimum one idle input cycle per block.
- in_ready depends only on registered state; no combinational path from out_ready to in_ready.

## Configuration
- Macro `SRA_ACC_SATURATE_EN`:
  - Defined: if acc + beat ≥ 2^ACC_WIDTH, acc ← all-ones and the sticky sat flag is set. out_sat reports it for the block; the flag clears on result consumption, `clear`, or reset.
  - Undefined: accumulation wraps and out_sat is tied 0.

## Structure
- Package `sra_pkg`:
  - state enum (ACCUM, HOLD)
  - default WIDTH/BEATS/ACC_WIDTH constants
  - clog2 function
- Sub-module `sra_acc_addsat`: combinational ACC_WIDTH adder that returns sum and overflow. The saturation mux is compiled under `SRA_ACC_SATURATE_EN`.
- The accumulator top holds the FSM, registers, and handshake.

## Test plan
All scenarios use WIDTH=10, BEATS=4, ACC_WIDTH=12.
- Beats s=1,2,3,4, c_out=0, back-to-back → out_valid one cycle after 4th accept; out_sum=10, out_count=4, out_sat=0.
- Beat s=100, c_out=0, then s=5, c_out=1, in_last=1 → out_sum=1129, out_count=2.
- Block result with out_ready held low 5 cycles → out_valid, out_sum, out_count stable and in_ready=0 throughout; one cycle after out_ready, in_ready=1 and the next block starts from 0.
- Four beats of s=0x3FF, c_out=1 (2047 each):
  - SATURATE defined → out_sum=0xFFF, out_sat=1.
  - SATURATE undefined → out_sum=0xFFC (8188 mod 4096), out_sat=0.
- Two beats of 50, then clear together with a valid beat, then four beats of 1 → first block discarded; out_sum=4, out_count=4.
- rst_n pulsed low asynchronously (mid-cycle) during HOLD → out_valid=0 and in_ready=1 immediately; after release, a fresh 4-beat block of 1s yields out_sum=4.
